// File: rtl/maxpool2x2_stream.sv
`default_nettype none
// ============================================================================
// Module : maxpool2x2_stream
// Brief  : Streaming 2x2 / stride-2 max-pool over a raster IEEE-754 pixel stream.
// Rev    : 1.0  initial release
// ============================================================================
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 6,
  parameter int HEIGHT     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int c_pool_w = WIDTH / 2;
  localparam int c_pool_h = HEIGHT / 2;
  localparam int c_col_w  = $clog2(WIDTH);
  localparam int c_row_w  = $clog2(HEIGHT);
  localparam int c_idx_w  = (c_pool_w > 1) ? $clog2(c_pool_w) : 1;

  localparam logic [1:0] c_EVEN_ROW = 2'd0;
  localparam logic [1:0] c_ODD_ROW  = 2'd1;
  localparam logic [1:0] c_DROP_ROW = 2'd2;

  // Sign-magnitude ordering on raw bits: +0 ranks above -0, NaNs are just patterns.
  function automatic logic f_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
      return ~a[DATA_WIDTH-1];
    else if (!a[DATA_WIDTH-1])
      return a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
    else
      return a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_max(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    return f_gt(b, a) ? b : a;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [c_col_w-1:0]    col_q, col_d;
  logic [c_row_w-1:0]    row_q, row_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                  valid_out_q, valid_out_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] rowbuf_q [c_pool_w];

  logic                  w_end_row;
  logic                  w_end_frame;
  logic                  w_even_col;
  logic                  w_odd_col;
  logic                  w_wr_en;
  logic [c_idx_w-1:0]    w_idx;
  logic [DATA_WIDTH-1:0] w_pairmax;
  logic [DATA_WIDTH-1:0] w_result;

  assign w_end_row   = valid_in && (col_q == c_col_w'(WIDTH - 1));
  assign w_end_frame = w_end_row && (row_q == c_row_w'(HEIGHT - 1));
  // An odd WIDTH leaves a trailing even column with no partner; it is excluded here.
  assign w_even_col  = !col_q[0] && (32'(col_q) < 32'(2 * c_pool_w));
  assign w_odd_col   = col_q[0];
  assign w_idx       = c_idx_w'(col_q >> 1);
  assign w_pairmax   = f_max(pair_q, i_data);
  assign w_result    = f_max(rowbuf_q[w_idx], w_pairmax);
  assign w_wr_en     = valid_in && w_odd_col && (state_q == c_EVEN_ROW);

  always_ff @(posedge clk) begin
    if (rst) state_q <= c_EVEN_ROW;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (w_end_frame) begin
      state_d = c_EVEN_ROW;
    end else if (w_end_row) begin
      case (state_q)
        c_EVEN_ROW: state_d = c_ODD_ROW;
        c_ODD_ROW:  state_d = (32'(row_q) + 32'd1 == 32'(2 * c_pool_h)) ? c_DROP_ROW : c_EVEN_ROW;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    o_data_d     = o_data_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    if (valid_in && w_odd_col && (state_q == c_ODD_ROW)) begin
      o_data_d     = w_result;
      valid_out_d  = 1'b1;
      frame_done_d = (32'(row_q) == 32'(2 * c_pool_h - 1)) &&
                     (32'(col_q) == 32'(2 * c_pool_w - 1));
    end
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    pair_d = pair_q;
    if (valid_in) begin
      col_d = w_end_row ? '0 : col_q + c_col_w'(1);
      if (w_end_row)
        row_d = w_end_frame ? '0 : row_q + c_row_w'(1);
      if (w_even_col && (state_q != c_DROP_ROW))
        pair_d = i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      o_data_q     <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      o_data_q     <= o_data_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Row buffer contents are never read before being rewritten in a fresh frame.
  always_ff @(posedge clk) begin
    if (w_wr_en) rowbuf_q[w_idx] <= w_pairmax;
  end

  assign o_data     = o_data_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool2x2_stream.sv
`default_nettype none
// ============================================================================
// Module : tb_maxpool2x2_stream
// Brief  : Scoreboard bench for a 4x4 and a 5x5 instance of maxpool2x2_stream.
// Rev    : 1.0  initial release
// ============================================================================
module tb_maxpool2x2_stream;

  typedef struct packed {
    logic [31:0] d;
    logic        fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d4 = '0, d5 = '0;
  logic        v4 = 1'b0, v5 = 1'b0;
  logic        p4 = 1'b0, p5 = 1'b0;
  logic [31:0] o4, o5;
  logic        vo4, vo5, fd4, fd5;

  exp_t        q4[$];
  exp_t        q5[$];
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  logic        ev4_q = 1'b0, ev5_q = 1'b0, rst_q = 1'b1;
  logic [31:0] last4 = '0, last5 = '0;

  logic [31:0] fa [16] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'hC0000000,
                           32'h3F000000, 32'h40800000, 32'hC0000000, 32'hC0000000,
                           32'h00000000, 32'h80000000, 32'h40400000, 32'h3F800000,
                           32'hBF800000, 32'hC0000000, 32'h3E800000, 32'h41000000};
  logic [31:0] exa [4] = '{32'h40800000, 32'hBF800000, 32'h00000000, 32'h41000000};
  logic [31:0] fb [16] = '{32'h40A00000, 32'h40C00000, 32'h3F800000, 32'h3F800000,
                           32'h40E00000, 32'hC1000000, 32'h3F800001, 32'h3F800000,
                           32'h80000000, 32'hBF800000, 32'h41200000, 32'h41100000,
                           32'hC0400000, 32'hBF000000, 32'h41400000, 32'h41300000};
  logic [31:0] exb [4] = '{32'h40E00000, 32'h3F800001, 32'h80000000, 32'h41400000};
  logic [31:0] ex5 [4] = '{32'h40E00000, 32'h41100000, 32'h41880000, 32'h41980000};

  always #5 clk = ~clk;

  maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_data(d4), .valid_in(v4),
    .o_data(o4), .valid_out(vo4), .frame_done(fd4)
  );

  maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(5), .HEIGHT(5)) u_dut5 (
    .clk(clk), .rst(rst), .i_data(d5), .valid_in(v5),
    .o_data(o5), .valid_out(vo5), .frame_done(fd5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Small positive integer to single-precision bits (exact for n < 2^24).
  function automatic logic [31:0] i2f(input int n);
    int e;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h007F_FFFF)};
  endfunction

  // Reference pulse timing: an output is due one edge after a producing beat.
  initial forever begin
    @(posedge clk);
    ev4_q = rst ? 1'b0 : (v4 & p4);
    ev5_q = rst ? 1'b0 : (v5 & p5);
    rst_q = rst;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_en) begin
      check("vo4_timing", 32'(vo4), 32'(ev4_q));
      if (rst_q) begin
        check("rst_o4", o4, 32'h0);
        check("rst_fd4", 32'(fd4), 32'h0);
        last4 = '0;
      end else if (vo4) begin
        if (q4.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out4 actual=%h required=none", o4);
        end else begin
          e = q4.pop_front();
          check("o4_data", o4, e.d);
          check("o4_frame_done", 32'(fd4), 32'(e.fd));
        end
        last4 = o4;
      end else begin
        check("o4_hold", o4, last4);
        check("fd4_idle", 32'(fd4), 32'h0);
      end

      check("vo5_timing", 32'(vo5), 32'(ev5_q));
      if (rst_q) begin
        check("rst_o5", o5, 32'h0);
        last5 = '0;
      end else if (vo5) begin
        if (q5.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out5 actual=%h required=none", o5);
        end else begin
          e = q5.pop_front();
          check("o5_data", o5, e.d);
          check("o5_frame_done", 32'(fd5), 32'(e.fd));
        end
        last5 = o5;
      end else begin
        check("o5_hold", o5, last5);
        check("fd5_idle", 32'(fd5), 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [31:0] px [16], input logic [31:0] ex [4],
                       input bit gaps, input int nbeats);
    int k;
    exp_t e;
    k = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) tick();
      v4 = 1'b1;
      d4 = px[i];
      p4 = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
      if (p4) begin
        e.d  = ex[k];
        e.fd = (k == 3);
        q4.push_back(e);
        k++;
      end
      tick();
      v4 = 1'b0;
      p4 = 1'b0;
      d4 = $urandom;
    end
  endtask

  task automatic send5();
    int k, r, c;
    exp_t e;
    k = 0;
    for (int i = 0; i < 25; i++) begin
      r = i / 5;
      c = i % 5;
      v5 = 1'b1;
      d5 = i2f(i + 1);
      p5 = (r == 1 || r == 3) && (c == 1 || c == 3);
      if (p5) begin
        e.d  = ex5[k];
        e.fd = (k == 3);
        q5.push_back(e);
        k++;
      end
      tick();
      v5 = 1'b0;
      p5 = 1'b0;
      d5 = $urandom;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    send4(fa, exa, 1'b0, 16);
    repeat (3) tick();
    send4(fa, exa, 1'b1, 16);
    repeat (3) tick();
    send5();
    repeat (3) tick();
    send4(fa, exa, 1'b0, 16);
    send4(fb, exb, 1'b0, 16);
    repeat (3) tick();

    send4(fa, exa, 1'b0, 6);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    send4(fa, exa, 1'b0, 16);
    repeat (4) tick();

    check("q4_drained", 32'(q4.size()), 32'h0);
    check("q5_drained", 32'(q5.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
